// File: rtl/l2_writeback_queue_if.sv
// l2_writeback_queue_if: L2-side request/response and arbiter-side drain signals
// of the write-back queue, with master (L2 + arbiter) and slave (queue) views.
interface l2_writeback_queue_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata;
    logic              wbq_hit;
    logic              wbq_resp;
    logic [LINE_W-1:0] wbq_rdata;
    logic              wbq_full;
    logic              ewb_write;
    logic [ADDR_W-1:0] ewb_addr;
    logic [LINE_W-1:0] ewb_wdata;
    logic              arb_ewb_resp;

    modport master (
        output cache_read, cache_write, cache_addr, cache_wdata, arb_ewb_resp,
        input  wbq_hit, wbq_resp, wbq_rdata, wbq_full, ewb_write, ewb_addr, ewb_wdata
    );

    modport slave (
        input  cache_read, cache_write, cache_addr, cache_wdata, arb_ewb_resp,
        output wbq_hit, wbq_resp, wbq_rdata, wbq_full, ewb_write, ewb_addr, ewb_wdata
    );
endinterface

// File: rtl/l2_writeback_queue.sv
// l2_writeback_queue: circular write-back FIFO between L2 and the pmem arbiter;
// coalesces repeat evictions into non-head entries and forwards queued lines to reads.
module l2_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    l2_writeback_queue_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - 5;
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW:0]       r_count;
    logic              r_resp;
    logic [LINE_W-1:0] r_rdata;

    logic [TAG_W-1:0] w_tag;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_nh_match;
    logic [PW-1:0]    w_coal_idx;
    logic [PW-1:0]    w_young_idx;
    logic [PW-1:0]    w_scan;
    logic             w_gate;
    logic             w_wr;
    logic             w_coal;
    logic             w_push;
    logic             w_pop;
    logic             w_rd_hit;
    logic             w_full;
    logic             w_unused_lsb;

    assign w_tag        = bus.cache_addr[ADDR_W-1:5];
    assign w_unused_lsb = ^bus.cache_addr[4:0];
    assign w_full       = r_count == CNT_FULL;

    // Youngest match is found by walking from head towards tail; last hit wins.
    always_comb begin
        w_match     = '0;
        w_nh_match  = '0;
        w_coal_idx  = '0;
        w_young_idx = r_rd_ptr;
        w_scan      = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i]    = r_valid[i] && (r_tag[i] == w_tag);
            w_nh_match[i] = w_match[i] && (PW'(i) != r_rd_ptr);
            if (w_nh_match[i]) w_coal_idx = PW'(i);
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_scan = r_rd_ptr + PW'(k);
            if (w_match[w_scan]) w_young_idx = w_scan;
        end
    end

    // While a response is out the requester still holds the old request.
    assign w_gate   = !r_resp;
    assign w_wr     = bus.cache_write && w_gate;
    assign w_coal   = w_wr && |w_nh_match;
    assign w_push   = w_wr && !w_coal && !w_full;
    assign w_rd_hit = bus.cache_read && !bus.cache_write && w_gate && |w_match;
    assign w_pop    = bus.arb_ewb_resp && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_resp   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_resp  <= w_coal || w_push || w_rd_hit;
            if (w_rd_hit) r_rdata <= r_data[w_young_idx];
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && PW'(i) == r_rd_ptr) r_valid[i] <= 1'b0;
                if (w_push && PW'(i) == r_wr_ptr) r_valid[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr]  <= w_tag;
            r_data[r_wr_ptr] <= bus.cache_wdata;
        end
        if (w_coal) r_data[w_coal_idx] <= bus.cache_wdata;
    end

    assign bus.wbq_hit   = bus.cache_read && |w_match;
    assign bus.wbq_resp  = r_resp;
    assign bus.wbq_rdata = r_rdata;
    assign bus.wbq_full  = w_full;
    assign bus.ewb_write = r_count != '0;
    assign bus.ewb_addr  = {r_tag[r_rd_ptr], 5'b0};
    assign bus.ewb_wdata = r_data[r_rd_ptr];
endmodule
